// File: rtl/cache_params.sv
// rtl/cache_params.sv - shared geometry, status-array field positions and FSM encodings for the icache lookup
package cache_params;

    localparam int TAG_W     = 8;
    localparam int SET_W     = 4;
    localparam int OFFS_W    = 4;
    localparam int NUM_WAYS  = 4;
    localparam int DA_WORD_W = 20;
    localparam int ADDR_W    = TAG_W + SET_W + OFFS_W;

    // Each way owns a {valid, mru} pair in the status array word
    localparam int SA_WAY_W  = 2;
    localparam int VALID_BIT = 1;
    localparam int MRU_BIT   = 0;

    localparam logic [1:0] RUN       = 2'd0;
    localparam logic [1:0] MISS_WAIT = 2'd1;
    localparam logic [1:0] REPLAY    = 2'd2;

endpackage

// File: rtl/tag_match_unit.sv
// rtl/tag_match_unit.sv - combinational 4-way tag compare, one-hot result with lowest way winning
module tag_match_unit
    import cache_params::*;
(
    input  logic [TAG_W-1:0]             tag,
    input  logic [NUM_WAYS*TAG_W-1:0]    ta_word,
    input  logic [NUM_WAYS*SA_WAY_W-1:0] sa_word,
    output logic [NUM_WAYS-1:0]          way_mask,
    output logic                         hit
);

    logic [NUM_WAYS-1:0] way_valid;
    logic [NUM_WAYS-1:0] mru_unused;

    always_comb begin
        way_valid  = '0;
        mru_unused = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            way_valid[w]  = sa_word[w*SA_WAY_W + VALID_BIT];
            mru_unused[w] = sa_word[w*SA_WAY_W + MRU_BIT];
        end
    end

    // Once a way has matched, higher ways are ignored so the mask stays one-hot
    always_comb begin
        way_mask = '0;
        hit      = 1'b0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!hit && way_valid[w] && (ta_word[w*TAG_W +: TAG_W] == tag)) begin
                way_mask[w] = 1'b1;
                hit         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cache_lookup_stage.sv
// rtl/cache_lookup_stage.sv - icache lookup pipeline: SRAM read, tag compare, hit return, miss handoff and replay
module cache_lookup_stage
    import cache_params::*;
(
    input  logic                          clk,
    input  logic                          arst_n,
    input  logic [ADDR_W-1:0]             i_addr,
    input  logic                          i_addr_valid,
    output logic                          o_ready,
    output logic                          o_arrays_read_en,
    output logic [SET_W-1:0]              o_ta_read_addr,
    output logic [SET_W-1:0]              o_sa_read_addr,
    output logic [SET_W+OFFS_W-1:0]       o_da_read_addr,
    input  logic [NUM_WAYS*TAG_W-1:0]     i_ta_read_data,
    input  logic [NUM_WAYS*SA_WAY_W-1:0]  i_sa_read_data,
    input  logic [NUM_WAYS*DA_WORD_W-1:0] i_da_read_data,
    input  logic                          i_miss_state,
    input  logic                          i_halt,
    output logic                          o_cache_hit,
    output logic [TAG_W-1:0]              o_tag_bits,
    output logic [SET_W-1:0]              o_set_bits,
    output logic [OFFS_W-1:0]             o_block_offset_bits,
    output logic [NUM_WAYS*SA_WAY_W-1:0]  o_status_array_data,
    output logic                          o_valid,
    output logic [DA_WORD_W-1:0]          o_hit_word,
    output logic                          o_hit_word_valid,
    output logic [NUM_WAYS-1:0]           o_hit_way_mask
);

    logic [1:0]                state;
    logic                      miss_seen;
    logic                      s1_valid;
    logic [ADDR_W-1:0]         s1_addr;
    logic [ADDR_W-1:0]         replay_addr;
    logic [NUM_WAYS-1:0]       s1_mask;
    logic                      s1_hit;
    logic                      s1_miss;
    logic [DA_WORD_W-1:0]      s1_word;
    logic                      run_go;
    logic                      replay_go;
    logic                      accept;
    logic [SET_W+OFFS_W-1:0]   s0_index;

    tag_match_unit u_tag_match (
        .tag      (s1_addr[SET_W+OFFS_W +: TAG_W]),
        .ta_word  (i_ta_read_data),
        .sa_word  (i_sa_read_data),
        .way_mask (s1_mask),
        .hit      (s1_hit)
    );

    assign s1_miss   = s1_valid & ~s1_hit;
    assign run_go    = (state == RUN) & ~i_halt;
    assign replay_go = (state == REPLAY) & ~i_halt;
    assign o_ready   = run_go & ~s1_miss;
    assign accept    = o_ready & i_addr_valid;

    // During REPLAY the SRAMs are re-addressed from the saved miss, not the fetch port
    assign s0_index         = (state == REPLAY) ? replay_addr[SET_W+OFFS_W-1:0]
                                                : i_addr[SET_W+OFFS_W-1:0];
    assign o_arrays_read_en = accept | replay_go;
    assign o_ta_read_addr   = s0_index[OFFS_W +: SET_W];
    assign o_sa_read_addr   = s0_index[OFFS_W +: SET_W];
    assign o_da_read_addr   = s0_index;

    always_comb begin
        s1_word = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (s1_mask[w]) begin
                s1_word = s1_word | i_da_read_data[w*DA_WORD_W +: DA_WORD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state       <= RUN;
            miss_seen   <= 1'b0;
            s1_valid    <= 1'b0;
            s1_addr     <= '0;
            replay_addr <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (run_go) begin
                        if (s1_miss) begin
                            s1_valid    <= 1'b0;
                            replay_addr <= s1_addr;
                            state       <= MISS_WAIT;
                        end else begin
                            s1_valid <= accept;
                            if (accept) begin
                                s1_addr <= i_addr;
                            end
                        end
                    end
                end
                MISS_WAIT: begin
                    // Leave only on the falling edge of the fill indication
                    if (i_miss_state) begin
                        miss_seen <= 1'b1;
                    end else if (miss_seen) begin
                        miss_seen <= 1'b0;
                        state     <= REPLAY;
                    end
                end
                REPLAY: begin
                    if (replay_go) begin
                        s1_valid <= 1'b1;
                        s1_addr  <= replay_addr;
                        state    <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            o_valid             <= 1'b0;
            o_cache_hit         <= 1'b0;
            o_tag_bits          <= '0;
            o_set_bits          <= '0;
            o_block_offset_bits <= '0;
            o_status_array_data <= '0;
            o_hit_word          <= '0;
            o_hit_word_valid    <= 1'b0;
            o_hit_way_mask      <= '0;
        end else if (run_go) begin
            o_valid             <= s1_valid;
            o_cache_hit         <= s1_valid & s1_hit;
            o_tag_bits          <= s1_addr[SET_W+OFFS_W +: TAG_W];
            o_set_bits          <= s1_addr[OFFS_W +: SET_W];
            o_block_offset_bits <= s1_addr[OFFS_W-1:0];
            o_status_array_data <= i_sa_read_data;
            o_hit_word          <= s1_valid ? s1_word : '0;
            o_hit_word_valid    <= s1_valid & s1_hit;
            o_hit_way_mask      <= s1_valid ? s1_mask : '0;
        end else begin
            // Frozen on stall, but the hit strobe must not repeat
            o_hit_word_valid <= 1'b0;
            if ((state == MISS_WAIT) && i_miss_state) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
